// File: rtl/ls11_sweep_tester.sv
// Exhaustive sweep tester for a triple 3-input AND gate model.
// Drives all 512 input vectors and waits SETTLE_CYCLES cycles before each sample.
// Compares Y against the expected AND results, then reports pass, the mismatch
// count and the first failing vector.
module ls11_sweep_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_start,
  input  logic       in_abort,
  input  logic [2:0] in_y,
  output logic [8:0] out_drv,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_pass,
  output logic [9:0] out_err_cnt,
  output logic       out_fail_valid,
  output logic [8:0] out_first_fail
);

  localparam int unsigned VEC_W = 9;
  localparam int unsigned ERR_W = 10;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;

  // With no settle time each vector is checked on the very next edge.
  localparam logic [1:0]       ST_AFTER_VEC = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC     = VEC_W'(511);

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [VEC_W-1:0] drv_d, first_fail_d;
  logic             busy_d, done_d, pass_d, fail_valid_d;
  logic [ERR_W-1:0] err_cnt_d, err_inc;
  logic [2:0]       exp_y;
  logic             mismatch;

  // Expected gate outputs for the vector currently on the bus.
  assign exp_y    = {&out_drv[8:6], &out_drv[5:3], &out_drv[2:0]};
  assign mismatch = (in_y != exp_y);
  assign err_inc  = out_err_cnt + ERR_W'(mismatch);

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      out_drv        <= '0;
      out_busy       <= 1'b0;
      out_done       <= 1'b0;
      out_pass       <= 1'b0;
      out_err_cnt    <= '0;
      out_fail_valid <= 1'b0;
      out_first_fail <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      out_drv        <= drv_d;
      out_busy       <= busy_d;
      out_done       <= done_d;
      out_pass       <= pass_d;
      out_err_cnt    <= err_cnt_d;
      out_fail_valid <= fail_valid_d;
      out_first_fail <= first_fail_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    drv_d        = out_drv;
    busy_d       = out_busy;
    done_d       = 1'b0;
    pass_d       = out_pass;
    err_cnt_d    = out_err_cnt;
    fail_valid_d = out_fail_valid;
    first_fail_d = out_first_fail;
    case (state)
      ST_IDLE: begin
        if (in_start) begin
          state_d      = ST_AFTER_VEC;
          cnt_d        = '0;
          drv_d        = '0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
        end
      end
      ST_SETTLE: begin
        if (in_abort) begin
          state_d = ST_IDLE;
          drv_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (in_abort) begin
          state_d = ST_IDLE;
          drv_d   = '0;
          busy_d  = 1'b0;
        end else begin
          err_cnt_d = err_inc;
          if (mismatch && !out_fail_valid) begin
            fail_valid_d = 1'b1;
            first_fail_d = out_drv;
          end
          if (out_drv == LAST_VEC) begin
            state_d = ST_IDLE;
            drv_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc == '0);
          end else begin
            state_d = ST_AFTER_VEC;
            cnt_d   = '0;
            drv_d   = out_drv + VEC_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ls11_sweep_tester.sv
// Bench for ls11_sweep_tester: two instances (settle 2 and settle 0) share the
// control inputs; each one's Y comes from a behavioural gate model with selectable faults.
module tb_ls11_sweep_tester;

  localparam int MODE_GOLD  = 0;
  localparam int MODE_ZERO  = 1;
  localparam int MODE_STUCK = 2;
  localparam int MODE_RAND  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] y2, y0;
  logic [8:0] drv2, drv0, ff2, ff0;
  logic       busy2, busy0, done2, done0, pass2, pass0, fv2, fv0;
  logic [9:0] err2, err0;

  int         mode = MODE_GOLD;
  logic [2:0] corrupt [512];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         done2_n = 0, done0_n = 0, done2_cyc = 0, done0_cyc = 0;

  always #5 clk = ~clk;

  ls11_sweep_tester #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_start(start), .in_abort(abort), .in_y(y2),
    .out_drv(drv2), .out_busy(busy2), .out_done(done2), .out_pass(pass2),
    .out_err_cnt(err2), .out_fail_valid(fv2), .out_first_fail(ff2)
  );

  ls11_sweep_tester #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_start(start), .in_abort(abort), .in_y(y0),
    .out_drv(drv0), .out_busy(busy0), .out_done(done0), .out_pass(pass0),
    .out_err_cnt(err0), .out_fail_valid(fv0), .out_first_fail(ff0)
  );

  // SN74LS11: Y1 = 1A.2A.3A, Y2 = 1B.2B.3B, Y3 = 1C.2C.3C.
  function automatic logic [2:0] ls11(input logic [8:0] v);
    return {v[8] & v[7] & v[6], v[5] & v[4] & v[3], v[2] & v[1] & v[0]};
  endfunction

  function automatic logic [2:0] faulty(input int m, input logic [8:0] v, input logic [2:0] c);
    case (m)
      MODE_ZERO:  return 3'b000;
      MODE_STUCK: return ls11(v) | 3'b010;
      MODE_RAND:  return ls11(v) ^ c;
      default:    return ls11(v);
    endcase
  endfunction

  always_comb begin
    y2 = faulty(mode, drv2, corrupt[drv2]);
    y0 = faulty(mode, drv0, corrupt[drv0]);
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (done2) begin done2_n++; done2_cyc = cyc; end
    if (done0) begin done0_n++; done0_cyc = cyc; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    done2_n = 0; done0_n = 0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    done2_n = 0; done0_n = 0;
  endtask

  task automatic wait_done2();
    int g = 0;
    while (done2_n == 0 && g < 4000) begin tick(); g++; end
    n_checks++; if (done2_n == 0) begin n_fail++; $display("FAIL done2_timeout got no done within %0d cycles", g); end
  endtask

  task automatic wait_done0();
    int g = 0;
    while (done0_n == 0 && g < 2000) begin tick(); g++; end
    n_checks++; if (done0_n == 0) begin n_fail++; $display("FAIL done0_timeout got no done within %0d cycles", g); end
  endtask

  task automatic test_reset();
    mode = MODE_GOLD;
    apply_reset();
    n_checks++; if (drv2 !== 9'd0 || busy2 !== 1'b0 || done2 !== 1'b0 || pass2 !== 1'b0)
      begin n_fail++; $display("FAIL reset_init got drv=%0d busy=%0b done=%0b pass=%0b want all 0", drv2, busy2, done2, pass2); end
    n_checks++; if (err2 !== 10'd0 || fv2 !== 1'b0 || ff2 !== 9'd0)
      begin n_fail++; $display("FAIL reset_init_res got err=%0d fv=%0b ff=%0d want all 0", err2, fv2, ff2); end
    start_pulse();
    repeat (50) tick();
    n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy got %0b want 1", busy2); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({drv2, busy2, done2, pass2, err2, fv2, ff2} !== '0 || {drv0, busy0, done0, pass0, err0, fv0, ff0} !== '0)
      begin n_fail++; $display("FAIL reset_async got drv2=%0d busy2=%0b err2=%0d drv0=%0d busy0=%0b want all 0", drv2, busy2, err2, drv0, busy0); end
    tick();
    rst_n = 1'b1;
    done2_n = 0; done0_n = 0;
    begin
      int busy_seen = 0;
      repeat (10) begin tick(); if (busy2 !== 1'b0 || busy0 !== 1'b0) busy_seen++; end
      n_checks++; if (busy_seen != 0 || done2_n != 0 || done0_n != 0)
        begin n_fail++; $display("FAIL reset_idle got busy_cycles=%0d dones=%0d want 0 0", busy_seen, done2_n + done0_n); end
    end
  endtask

  task automatic test_golden();
    mode = MODE_GOLD;
    apply_reset();
    start_pulse();
    n_checks++; if (busy2 !== 1'b1 || drv2 !== 9'd0) begin n_fail++; $display("FAIL golden_start got busy=%0b drv=%0d want 1 0", busy2, drv2); end
    wait_done2();
    n_checks++; if (done2_cyc - start_cyc != 1536) begin n_fail++; $display("FAIL golden_latency got %0d want 1536", done2_cyc - start_cyc); end
    n_checks++; if (pass2 !== 1'b1 || err2 !== 10'd0 || fv2 !== 1'b0 || busy2 !== 1'b0 || drv2 !== 9'd0)
      begin n_fail++; $display("FAIL golden_result got pass=%0b err=%0d fv=%0b busy=%0b drv=%0d want 1 0 0 0 0", pass2, err2, fv2, busy2, drv2); end
    tick();
    n_checks++; if (done2 !== 1'b0 || pass2 !== 1'b1) begin n_fail++; $display("FAIL golden_done_width got done=%0b pass=%0b want 0 1", done2, pass2); end
  endtask

  task automatic test_zero();
    mode = MODE_ZERO;
    apply_reset();
    start_pulse();
    wait_done0();
    n_checks++; if (done0_cyc - start_cyc != 512) begin n_fail++; $display("FAIL zero_latency got %0d want 512", done0_cyc - start_cyc); end
    n_checks++; if (err0 !== 10'd169 || ff0 !== 9'h007 || fv0 !== 1'b1 || pass0 !== 1'b0)
      begin n_fail++; $display("FAIL zero_result got err=%0d ff=%0d fv=%0b pass=%0b want 169 7 1 0", err0, ff0, fv0, pass0); end
  endtask

  task automatic test_stuck();
    mode = MODE_STUCK;
    apply_reset();
    start_pulse();
    wait_done2();
    n_checks++; if (err2 !== 10'd448 || ff2 !== 9'd0 || fv2 !== 1'b1 || pass2 !== 1'b0)
      begin n_fail++; $display("FAIL stuck_result got err=%0d ff=%0d fv=%0b pass=%0b want 448 0 1 0", err2, ff2, fv2, pass2); end
    n_checks++; if (done2_cyc - start_cyc != 1536) begin n_fail++; $display("FAIL stuck_latency got %0d want 1536", done2_cyc - start_cyc); end
  endtask

  task automatic test_random();
    int exp_err = 0;
    int exp_ff = -1;
    for (int i = 0; i < 512; i++) begin
      corrupt[i] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if (corrupt[i] != 3'd0) begin
        exp_err++;
        if (exp_ff < 0) exp_ff = i;
      end
    end
    mode = MODE_RAND;
    apply_reset();
    start_pulse();
    wait_done0();
    n_checks++; if (int'(err0) != exp_err || fv0 !== (exp_ff >= 0) || (exp_ff >= 0 && int'(ff0) != exp_ff) || pass0 !== (exp_err == 0))
      begin n_fail++; $display("FAIL rand_s0 got err=%0d fv=%0b ff=%0d pass=%0b want err=%0d ff=%0d", err0, fv0, ff0, pass0, exp_err, exp_ff); end
    wait_done2();
    n_checks++; if (int'(err2) != exp_err || fv2 !== (exp_ff >= 0) || (exp_ff >= 0 && int'(ff2) != exp_ff) || pass2 !== (exp_err == 0))
      begin n_fail++; $display("FAIL rand_s2 got err=%0d fv=%0b ff=%0d pass=%0b want err=%0d ff=%0d", err2, fv2, ff2, pass2, exp_err, exp_ff); end
  endtask

  task automatic test_abort();
    int exp_err = 0;
    int exp_ff = -1;
    int g = 0;
    for (int i = 0; i < 100; i++) begin
      if (corrupt[i] != 3'd0) begin
        exp_err++;
        if (exp_ff < 0) exp_ff = i;
      end
    end
    mode = MODE_RAND;
    apply_reset();
    start_pulse();
    while (drv2 !== 9'd100 && g < 600) begin tick(); g++; end
    n_checks++; if (drv2 !== 9'd100) begin n_fail++; $display("FAIL abort_reach got drv=%0d want 100", drv2); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (busy2 !== 1'b0 || drv2 !== 9'd0 || done2_n != 0 || pass2 !== 1'b0)
      begin n_fail++; $display("FAIL abort_stop got busy=%0b drv=%0d dones=%0d pass=%0b want 0 0 0 0", busy2, drv2, done2_n, pass2); end
    repeat (5) tick();
    n_checks++; if (int'(err2) != exp_err || fv2 !== (exp_ff >= 0) || (exp_ff >= 0 && int'(ff2) != exp_ff) || done2_n != 0)
      begin n_fail++; $display("FAIL abort_frozen got err=%0d fv=%0b ff=%0d dones=%0d want err=%0d ff=%0d", err2, fv2, ff2, done2_n, exp_err, exp_ff); end
    mode = MODE_GOLD;
    start_pulse();
    n_checks++; if (err2 !== 10'd0 || fv2 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL abort_restart got err=%0d fv=%0b busy=%0b want 0 0 1", err2, fv2, busy2); end
    wait_done2();
    n_checks++; if (pass2 !== 1'b1 || err2 !== 10'd0 || done2_cyc - start_cyc != 1536)
      begin n_fail++; $display("FAIL abort_regolden got pass=%0b err=%0d lat=%0d want 1 0 1536", pass2, err2, done2_cyc - start_cyc); end
  endtask

  task automatic test_back_to_back();
    int busy_drop = 0;
    mode = MODE_GOLD;
    apply_reset();
    start_pulse();
    for (int k = 1; k <= 1536; k++) begin
      start = (k == 1536) || (k % 200 == 57);
      tick();
      if (k < 1536 && busy2 !== 1'b1) busy_drop++;
    end
    start = 1'b0;
    n_checks++; if (busy_drop != 0 || done2 !== 1'b1 || done2_n != 1 || done2_cyc - start_cyc != 1536)
      begin n_fail++; $display("FAIL b2b_ignore got drops=%0d done=%0b dones=%0d lat=%0d want 0 1 1 1536", busy_drop, done2, done2_n, done2_cyc - start_cyc); end
    n_checks++; if (pass2 !== 1'b1 || busy2 !== 1'b0) begin n_fail++; $display("FAIL b2b_pass got pass=%0b busy=%0b want 1 0", pass2, busy2); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy2 !== 1'b1 || drv2 !== 9'd0 || pass2 !== 1'b0 || done2 !== 1'b0)
      begin n_fail++; $display("FAIL b2b_restart got busy=%0b drv=%0d pass=%0b done=%0b want 1 0 0 0", busy2, drv2, pass2, done2); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) corrupt[i] = 3'd0;
    test_reset();
    test_golden();
    test_zero();
    test_stuck();
    test_random();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
